rd_req_scheduler: RTL and testbench

- Sequences CCI-P c0 read requests for one copy/grayscale job: walks src_base..src_base+num_lines-1, one request per cycle max.
- Throttles on channel almost-full, downstream write-FIFO almost-full and an outstanding-read credit limit.
- Counts read responses and signals job completion or abort drain.
- Sits between the CSR block (job config, start/abort) and the c0 Tx register stage of the application top.

---
 rtl/rd_sched_pkg.sv | 17 +
 rtl/rd_credit_counter.sv | 40 ++++
 rtl/rd_req_scheduler.sv | 174 +++++++++++++++++
 tb/tb_rd_req_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_sched_pkg.sv
// Shared types and default widths for the c0 read-request scheduler.
package rd_sched_pkg;

    localparam int unsigned RD_ADDR_WIDTH    = 42;
    localparam int unsigned RD_CNT_WIDTH     = 32;
    localparam int unsigned RD_TAG_WIDTH     = 16;
    localparam int unsigned RD_OUT_WIDTH     = 8;
    localparam int unsigned RD_MAX_OUTSTANDING_DFLT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_rd_sched_state;

endpackage

// File: rtl/rd_credit_counter.sv
// Up/down in-flight read counter; a decrement at zero holds and flags underflow.
module rd_credit_counter #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_limit_c,
    output logic             underflow_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign at_limit_c  = (count_q >= CNT_W'(LIMIT));
    assign underflow_c = dec_i && !inc_i && (count_q == '0);
    assign count_o     = count_q;

    // Simultaneous inc/dec cancel out.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rd_req_scheduler.sv
// Issues one c0 read request per cycle over a job's source lines, throttled by
// almost-full signals and an in-flight credit limit; drains responses to done.
module rd_req_scheduler
    import rd_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = RD_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH       = RD_CNT_WIDTH,
    parameter int unsigned TAG_WIDTH       = RD_TAG_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = RD_MAX_OUTSTANDING_DFLT
) (
    input  logic                    clk,
    input  logic                    Resetb,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   src_base,
    input  logic [CNT_WIDTH-1:0]    num_lines,
    input  logic                    c0_alm_full,
    input  logic                    c1_alm_full,
    input  logic                    wr_fifo_alm_full,
    input  logic                    rd_rsp_valid,
    output logic                    rd_req_valid,
    output logic [ADDR_WIDTH-1:0]   rd_req_addr,
    output logic [TAG_WIDTH-1:0]    rd_req_mdata,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [CNT_WIDTH-1:0]    req_cnt,
    output logic [CNT_WIDTH-1:0]    rsp_cnt,
    output logic [RD_OUT_WIDTH-1:0] outstanding,
    output logic                    err_unexp_rsp
);

    t_rd_sched_state state_q, state_d;

    logic [ADDR_WIDTH-1:0]   src_base_q, src_base_d;
    logic [CNT_WIDTH-1:0]    num_lines_q, num_lines_d;
    logic [CNT_WIDTH-1:0]    req_cnt_q, req_cnt_d;
    logic [CNT_WIDTH-1:0]    rsp_cnt_q, rsp_cnt_d;
    logic                    aborted_q, aborted_d;
    logic                    err_q, err_d;
    logic                    req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [TAG_WIDTH-1:0]    req_mdata_q, req_mdata_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    issue_c;
    logic                    last_c;
    logic                    at_limit_c;
    logic                    underflow_c;
    logic [RD_OUT_WIDTH-1:0] outstanding_w;

    // Abort suppresses the issue in the same cycle it is seen.
    assign issue_c = (state_q == ISSUE) && !c0_alm_full && !c1_alm_full &&
                     !wr_fifo_alm_full && !at_limit_c &&
                     (req_cnt_q < num_lines_q) && !abort;
    assign last_c  = ((req_cnt_q + CNT_WIDTH'(1)) == num_lines_q);

    rd_credit_counter #(
        .LIMIT (MAX_OUTSTANDING),
        .CNT_W (RD_OUT_WIDTH)
    ) u_credit (
        .clk         (clk),
        .rst_n       (Resetb),
        .inc_i       (issue_c),
        .dec_i       (rd_rsp_valid),
        .count_o     (outstanding_w),
        .at_limit_c  (at_limit_c),
        .underflow_c (underflow_c)
    );

    always_comb begin
        state_d     = state_q;
        src_base_d  = src_base_q;
        num_lines_d = num_lines_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        aborted_d   = aborted_q;
        err_d       = err_q | underflow_c;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        req_mdata_d = req_mdata_q;

        if (rd_rsp_valid && (state_q != IDLE)) begin
            rsp_cnt_d = rsp_cnt_q + CNT_WIDTH'(1);
        end

        if (issue_c) begin
            req_valid_d = 1'b1;
            req_addr_d  = src_base_q + ADDR_WIDTH'(req_cnt_q);
            req_mdata_d = req_cnt_q[TAG_WIDTH-1:0];
            req_cnt_d   = req_cnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_base_d  = src_base;
                    num_lines_d = num_lines;
                    req_cnt_d   = '0;
                    rsp_cnt_d   = '0;
                    aborted_d   = 1'b0;
                    err_d       = 1'b0;
                    state_d     = (num_lines == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (issue_c && last_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((outstanding_w == RD_OUT_WIDTH'(0)) ||
                    ((outstanding_w == RD_OUT_WIDTH'(1)) && rd_rsp_valid)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge Resetb) begin
        if (!Resetb) begin
            state_q     <= IDLE;
            src_base_q  <= '0;
            num_lines_q <= '0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_mdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_base_q  <= src_base_d;
            num_lines_q <= num_lines_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_mdata_q <= req_mdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_req_valid  = req_valid_q;
    assign rd_req_addr   = req_addr_q;
    assign rd_req_mdata  = req_mdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign req_cnt       = req_cnt_q;
    assign rsp_cnt       = rsp_cnt_q;
    assign outstanding   = outstanding_w;
    assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_rd_req_scheduler.sv
// Self-checking bench for rd_req_scheduler: vector table, directed corner cases,
// and randomized jobs against a job-level reference model.
module tb_rd_req_scheduler;

    localparam int unsigned AW = 42;
    localparam int unsigned CW = 32;
    localparam int unsigned TW = 16;
    localparam int MAXO = 4;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          Resetb;
    logic          start, abort, c0, c1, wr, rsp;
    logic [AW-1:0] src_base;
    logic [CW-1:0] num_lines;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic [TW-1:0] rd_req_mdata;
    logic          busy, done, aborted, err_unexp_rsp;
    logic [CW-1:0] req_cnt, rsp_cnt;
    logic [7:0]    outstanding;

    rd_req_scheduler #(
        .ADDR_WIDTH      (AW),
        .CNT_WIDTH       (CW),
        .TAG_WIDTH       (TW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk              (clk),
        .Resetb           (Resetb),
        .start            (start),
        .abort            (abort),
        .src_base         (src_base),
        .num_lines        (num_lines),
        .c0_alm_full      (c0),
        .c1_alm_full      (c1),
        .wr_fifo_alm_full (wr),
        .rd_rsp_valid     (rsp),
        .rd_req_valid     (rd_req_valid),
        .rd_req_addr      (rd_req_addr),
        .rd_req_mdata     (rd_req_mdata),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted),
        .req_cnt          (req_cnt),
        .rsp_cnt          (rsp_cnt),
        .outstanding      (outstanding),
        .err_unexp_rsp    (err_unexp_rsp)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: job progress in plain counters.
    int            m_ph;
    int            m_out;
    logic [AW-1:0] m_base, m_addr;
    logic [CW-1:0] m_num, m_req, m_rsp;
    logic [TW-1:0] m_tag;
    bit            m_valid, m_busy, m_done, m_abt, m_err;

    int            nval;
    logic [TW-1:0] last_tag, prev_tag;

    typedef struct {
        bit            st;
        bit            ab;
        bit            rs;
        logic [AW-1:0] base;
        logic [CW-1:0] num;
        bit            v;
        logic [AW-1:0] a;
        logic [TW-1:0] t;
        bit            bsy;
        bit            dn;
        bit            abt;
        bit            err;
        logic [7:0]    out;
        logic [CW-1:0] req;
        logic [CW-1:0] rsc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input bit st, ab, rs, input logic [AW-1:0] base,
                                 input logic [CW-1:0] num, input bit v,
                                 input logic [AW-1:0] a, input logic [TW-1:0] t,
                                 input bit bsy, dn, abt, err, input logic [7:0] out,
                                 input logic [CW-1:0] req, rsc);
        vec_t r;
        r.st = st; r.ab = ab; r.rs = rs; r.base = base; r.num = num;
        r.v = v; r.a = a; r.t = t; r.bsy = bsy; r.dn = dn; r.abt = abt;
        r.err = err; r.out = out; r.req = req; r.rsc = rsc;
        return r;
    endfunction

    task automatic check(input string name, input bit ok, input string got_s,
                         input string want_s);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, want %s", name, got_s, want_s);
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_out = 0; m_base = '0; m_addr = '0; m_num = '0;
        m_req = '0; m_rsp = '0; m_tag = '0;
        m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_abt = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit st, ab, b0, b1, bw, rs,
                              input logic [AW-1:0] base, input logic [CW-1:0] num);
        bit iss;
        int old_out;
        int nxt;
        old_out = m_out;
        nxt     = m_ph;
        iss = (m_ph == P_ISSUE) && !b0 && !b1 && !bw && (m_out < MAXO) &&
              (m_req < m_num) && !ab;
        if (iss && !rs) m_out++;
        else if (rs && !iss) begin
            if (m_out == 0) m_err = 1'b1;
            else m_out--;
        end
        if (rs && (m_ph != P_IDLE)) m_rsp++;
        m_valid = iss;
        if (iss) begin
            m_addr = m_base + AW'(m_req);
            m_tag  = m_req[TW-1:0];
            m_req++;
        end
        case (m_ph)
            P_IDLE: if (st) begin
                m_base = base; m_num = num; m_req = '0; m_rsp = '0;
                m_abt = 1'b0; m_err = 1'b0;
                nxt = (num == '0) ? P_DONE : P_ISSUE;
            end
            P_ISSUE: begin
                if (ab) begin
                    m_abt = 1'b1;
                    nxt = P_DRAIN;
                end else if (iss && (m_req == m_num)) begin
                    nxt = P_DRAIN;
                end
            end
            P_DRAIN: if ((old_out == 0) || ((old_out == 1) && rs)) nxt = P_DONE;
            default: nxt = P_IDLE;
        endcase
        m_ph   = nxt;
        m_busy = (nxt != P_IDLE);
        m_done = (nxt == P_DONE);
    endtask

    task automatic cmp_model();
        bit ok;
        ok = (rd_req_valid == m_valid) && (busy == m_busy) && (done == m_done) &&
             (aborted == m_abt) && (err_unexp_rsp == m_err) &&
             (outstanding == 8'(m_out)) && (req_cnt == m_req) && (rsp_cnt == m_rsp);
        if (m_valid) ok = ok && (rd_req_addr == m_addr) && (rd_req_mdata == m_tag);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL model @%0t: got v=%0b a=%h t=%h busy=%0b done=%0b ab=%0b err=%0b out=%0d req=%0d rsp=%0d, want v=%0b a=%h t=%h busy=%0b done=%0b ab=%0b err=%0b out=%0d req=%0d rsp=%0d",
                      $time, rd_req_valid, rd_req_addr, rd_req_mdata, busy, done, aborted,
                      err_unexp_rsp, outstanding, req_cnt, rsp_cnt, m_valid, m_addr, m_tag,
                      m_busy, m_done, m_abt, m_err, m_out, m_req, m_rsp);
    endtask

    // One clock: drive inputs, advance model, sample after the edge.
    task automatic tick(input bit st, ab, b0, b1, bw, rs);
        start = st; abort = ab; c0 = b0; c1 = b1; wr = bw; rsp = rs;
        model_step(st, ab, b0, b1, bw, rs, src_base, num_lines);
        @(posedge clk);
        @(negedge clk);
        cmp_model();
        start = 1'b0; abort = 1'b0; c0 = 1'b0; c1 = 1'b0; wr = 1'b0; rsp = 1'b0;
        if (rd_req_valid) begin
            nval++;
            prev_tag = last_tag;
            last_tag = rd_req_mdata;
        end
    endtask

    task automatic run_to_idle(input int bound);
        int k;
        k = 0;
        while ((m_ph != P_IDLE) && (k < bound)) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_out > 0);
            k++;
        end
        if (m_ph != P_IDLE) check("run_to_idle", 1'b0, "timeout", "idle");
    endtask

    initial begin
        logic [63:0] rnd;
        bit ok;
        Resetb = 1'b0; start = 1'b0; abort = 1'b0; c0 = 1'b0; c1 = 1'b0; wr = 1'b0;
        rsp = 1'b0; src_base = '0; num_lines = '0;
        nval = 0; last_tag = '0; prev_tag = '0;
        model_reset();
        repeat (3) @(negedge clk);
        ok = !rd_req_valid && !busy && !done && !aborted && !err_unexp_rsp &&
             (req_cnt == '0) && (rsp_cnt == '0) && (outstanding == 8'd0) &&
             (rd_req_addr == '0) && (rd_req_mdata == '0);
        check("reset", ok, $sformatf("v=%0b busy=%0b out=%0d", rd_req_valid, busy, outstanding), "all zero");
        Resetb = 1'b1;

        // Basic job, zero-length job, spurious response, address wrap, ignored abort.
        tbl.push_back(mkv(1,0,0, 42'h1000, 4, 0, 42'h0,    0, 1,0,0,0, 0, 0, 0));
        tbl.push_back(mkv(0,0,0, 42'h1000, 4, 1, 42'h1000, 0, 1,0,0,0, 1, 1, 0));
        tbl.push_back(mkv(0,0,1, 42'h1000, 4, 1, 42'h1001, 1, 1,0,0,0, 1, 2, 1));
        tbl.push_back(mkv(0,0,1, 42'h1000, 4, 1, 42'h1002, 2, 1,0,0,0, 1, 3, 2));
        tbl.push_back(mkv(0,0,1, 42'h1000, 4, 1, 42'h1003, 3, 1,0,0,0, 1, 4, 3));
        tbl.push_back(mkv(0,0,1, 42'h1000, 4, 0, 42'h0,    0, 1,1,0,0, 0, 4, 4));
        tbl.push_back(mkv(0,0,0, 42'h1000, 4, 0, 42'h0,    0, 0,0,0,0, 0, 4, 4));
        tbl.push_back(mkv(1,0,0, 42'h5555, 0, 0, 42'h0,    0, 1,1,0,0, 0, 0, 0));
        tbl.push_back(mkv(0,0,0, 42'h5555, 0, 0, 42'h0,    0, 0,0,0,0, 0, 0, 0));
        tbl.push_back(mkv(0,0,1, 42'h5555, 0, 0, 42'h0,    0, 0,0,0,1, 0, 0, 0));
        tbl.push_back(mkv(1,0,0, 42'h3FF_FFFF_FFFF, 2, 0, 42'h0, 0, 1,0,0,0, 0, 0, 0));
        tbl.push_back(mkv(0,0,0, 42'h3FF_FFFF_FFFF, 2, 1, 42'h3FF_FFFF_FFFF, 0, 1,0,0,0, 1, 1, 0));
        tbl.push_back(mkv(0,0,1, 42'h3FF_FFFF_FFFF, 2, 1, 42'h0, 1, 1,0,0,0, 1, 2, 1));
        tbl.push_back(mkv(0,1,1, 42'h3FF_FFFF_FFFF, 2, 0, 42'h0, 0, 1,1,0,0, 0, 2, 2));
        tbl.push_back(mkv(0,1,0, 42'h3FF_FFFF_FFFF, 2, 0, 42'h0, 0, 0,0,0,0, 0, 2, 2));

        foreach (tbl[i]) begin
            src_base  = tbl[i].base;
            num_lines = tbl[i].num;
            tick(tbl[i].st, tbl[i].ab, 1'b0, 1'b0, 1'b0, tbl[i].rs);
            ok = (rd_req_valid == tbl[i].v) && (busy == tbl[i].bsy) && (done == tbl[i].dn) &&
                 (aborted == tbl[i].abt) && (err_unexp_rsp == tbl[i].err) &&
                 (outstanding == tbl[i].out) && (req_cnt == tbl[i].req) && (rsp_cnt == tbl[i].rsc);
            if (tbl[i].v) ok = ok && (rd_req_addr == tbl[i].a) && (rd_req_mdata == tbl[i].t);
            check($sformatf("vec%0d", i), ok,
                  $sformatf("v=%0b a=%h t=%h busy=%0b done=%0b ab=%0b err=%0b out=%0d req=%0d rsp=%0d",
                            rd_req_valid, rd_req_addr, rd_req_mdata, busy, done, aborted,
                            err_unexp_rsp, outstanding, req_cnt, rsp_cnt),
                  $sformatf("v=%0b a=%h t=%h busy=%0b done=%0b ab=%0b err=%0b out=%0d req=%0d rsp=%0d",
                            tbl[i].v, tbl[i].a, tbl[i].t, tbl[i].bsy, tbl[i].dn, tbl[i].abt,
                            tbl[i].err, tbl[i].out, tbl[i].req, tbl[i].rsc));
        end

        // Credit limit: responses withheld.
        src_base = 42'h2000; num_lines = 8;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nval = 0;
        repeat (8) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("credit_reqs", nval == MAXO, $sformatf("%0d", nval), $sformatf("%0d", MAXO));
        check("credit_out", outstanding == 8'(MAXO), $sformatf("%0d", outstanding), $sformatf("%0d", MAXO));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("credit_hold", !rd_req_valid && (outstanding == 8'(MAXO - 1)),
              $sformatf("v=%0b out=%0d", rd_req_valid, outstanding), $sformatf("v=0 out=%0d", MAXO - 1));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("credit_resume", rd_req_valid && (rd_req_addr == 42'h2004) && (rd_req_mdata == 16'd4),
              $sformatf("v=%0b a=%h t=%h", rd_req_valid, rd_req_addr, rd_req_mdata), "v=1 a=2004 t=4");
        run_to_idle(200);

        // c0 almost-full for 5 cycles mid-job.
        src_base = 42'h3000; num_lines = 20;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nval = 0;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_out > 0);
        check("bp_pre", nval == 3, $sformatf("%0d", nval), "3");
        nval = 0;
        repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_out > 0);
        check("bp_stall", nval == 0, $sformatf("%0d", nval), "0");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_out > 0);
        check("bp_resume", rd_req_valid && (rd_req_addr == 42'h3003),
              $sformatf("v=%0b a=%h", rd_req_valid, rd_req_addr), "v=1 a=3003");
        run_to_idle(200);
        check("bp_total", req_cnt == 20, $sformatf("%0d", req_cnt), "20");

        // Abort after 10 issued with 3 outstanding.
        src_base = 42'h4000; num_lines = 100;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; (k < 50) && (m_req < 10); k++)
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_out >= 3);
        check("abort_pre", (req_cnt == 10) && (outstanding == 8'd3),
              $sformatf("req=%0d out=%0d", req_cnt, outstanding), "req=10 out=3");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_set", !rd_req_valid && aborted && busy,
              $sformatf("v=%0b ab=%0b busy=%0b", rd_req_valid, aborted, busy), "v=0 ab=1 busy=1");
        nval = 0;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_done", (nval == 0) && done && aborted && (req_cnt == 10) && (rsp_cnt == 10),
              $sformatf("reqs=%0d done=%0b ab=%0b req=%0d rsp=%0d", nval, done, aborted, req_cnt, rsp_cnt),
              "reqs=0 done=1 ab=1 req=10 rsp=10");
        run_to_idle(10);

        // Reset asserted mid-ISSUE.
        src_base = 42'h6000; num_lines = 50;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 Resetb = 1'b0;
        #1;
        ok = !rd_req_valid && !busy && !done && !aborted && !err_unexp_rsp &&
             (req_cnt == '0) && (rsp_cnt == '0) && (outstanding == 8'd0);
        check("reset_mid", ok, $sformatf("v=%0b busy=%0b req=%0d out=%0d", rd_req_valid, busy, req_cnt, outstanding),
              "all zero");
        model_reset();
        @(negedge clk);
        Resetb = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized jobs with backpressure, stray start/abort and random response timing.
        for (int j = 0; j < 25; j++) begin
            rnd = {$urandom(), $urandom()};
            src_base  = (j % 4 == 0) ? 42'h3FF_FFFF_FFF0 + AW'($urandom_range(0, 15)) : rnd[AW-1:0];
            num_lines = CW'($urandom_range(0, 40));
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 0; (k < 3000) && (m_ph != P_IDLE); k++) begin
                tick($urandom_range(0, 30) == 0,
                     ((m_ph == P_ISSUE) && ($urandom_range(0, 60) == 0)) || ($urandom_range(0, 200) == 0),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 12) == 0,
                     $urandom_range(0, 7) == 0, (m_out > 0) && ($urandom_range(0, 2) != 0));
            end
            if (m_ph != P_IDLE) check("rand_timeout", 1'b0, "busy", "idle");
            tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Tag wrap at index 65536.
        src_base = 42'h0; num_lines = 65537;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nval = 0;
        run_to_idle(70000);
        check("wrap", (nval == 65537) && (last_tag == 16'h0000) && (prev_tag == 16'hFFFF),
              $sformatf("n=%0d last=%h prev=%h", nval, last_tag, prev_tag), "n=65537 last=0000 prev=ffff");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
